// File: rtl/aes_block_uart_streamer_if.sv
// rtl/aes_block_uart_streamer_if.sv - block intake and UART TX handshake bundle for aes_block_uart_streamer
interface aes_block_uart_streamer_if;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_done;

    modport master (
        output blk_valid, blk_data, tx_done,
        input  blk_ready, tx_data, tx_start
    );

    modport slave (
        input  blk_valid, blk_data, tx_done,
        output blk_ready, tx_data, tx_start
    );
endinterface

// File: rtl/aes_block_uart_streamer.sv
// rtl/aes_block_uart_streamer.sv - buffers 128-bit AES blocks and feeds them LSB byte first to a UART TX
// Optional trailing frame checksum byte: define AES_STREAM_CHECKSUM_EN.
module aes_block_uart_streamer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int BLOCK_COUNT = 4,
    localparam int IDX_W      = $clog2(BLOCK_COUNT) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    aes_block_uart_streamer_if.slave bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [IDX_W-1:0]      blk_index
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

`ifdef AES_STREAM_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT} state_t;
`endif

    logic [127:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             blk_ready_q;
    logic             push, pop;

    state_t           state_q, state_d;
    logic [127:0]     shreg_q, shreg_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0] blk_index_q, blk_index_d;
    logic             frame_done_q, frame_done_d;
`ifdef AES_STREAM_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
    logic             csum_phase_q, csum_phase_d;
`endif

    assign push    = bus.blk_valid && blk_ready_q;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Storage is not reset; validity is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.blk_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            blk_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            blk_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            byte_cnt_q   <= '0;
            blk_index_q  <= '0;
            frame_done_q <= 1'b0;
`ifdef AES_STREAM_CHECKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            byte_cnt_q   <= byte_cnt_d;
            blk_index_q  <= blk_index_d;
            frame_done_q <= frame_done_d;
`ifdef AES_STREAM_CHECKSUM_EN
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        byte_cnt_d   = byte_cnt_q;
        blk_index_d  = blk_index_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
`ifdef AES_STREAM_CHECKSUM_EN
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
`endif
        case (state_q)
            S_IDLE: if (count_q != '0) state_d = S_LOAD;
            S_LOAD: begin
                pop        = 1'b1;
                shreg_d    = mem_q[rd_ptr_q];
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: if (bus.tx_done) begin
`ifdef AES_STREAM_CHECKSUM_EN
                if (csum_phase_q) begin
                    csum_phase_d = 1'b0;
                    csum_d       = '0;
                    blk_index_d  = '0;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    csum_d = csum_q ^ shreg_q[7:0];
`else
                begin
`endif
                    shreg_d    = shreg_q >> 8;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q != 4'd15) begin
                        state_d = S_SEND;
                    end else if (blk_index_q == IDX_W'(BLOCK_COUNT - 1)) begin
`ifdef AES_STREAM_CHECKSUM_EN
                        blk_index_d = blk_index_q + IDX_W'(1);
                        state_d     = S_CSUM;
`else
                        blk_index_d  = '0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
`endif
                    end else begin
                        blk_index_d = blk_index_q + IDX_W'(1);
                        state_d     = (count_q != '0) ? S_LOAD : S_IDLE;
                    end
                end
            end
`ifdef AES_STREAM_CHECKSUM_EN
            // Checksum byte rides the shift register so SEND/WAIT stay unchanged.
            S_CSUM: begin
                shreg_d      = {120'd0, csum_q};
                csum_phase_d = 1'b1;
                state_d      = S_SEND;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.blk_ready = blk_ready_q;
    assign bus.tx_data   = shreg_q[7:0];
    assign bus.tx_start  = (state_q == S_SEND);
    assign busy          = (count_q != '0) || (state_q != S_IDLE);
    assign frame_done    = frame_done_q;
    assign blk_index     = blk_index_q;
endmodule

// File: tb/tb_aes_block_uart_streamer.sv
// tb/tb_aes_block_uart_streamer.sv - scoreboard bench for aes_block_uart_streamer with a 10-cycle UART responder
module tb_aes_block_uart_streamer;
    localparam int FD = 4;
`ifdef AES_STREAM_CHECKSUM_EN
    localparam int BC = 1;
    localparam int CS = 1;
`else
    localparam int BC = 4;
    localparam int CS = 0;
`endif
    localparam int IW = $clog2(BC) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_block_uart_streamer_if bus();
    logic          busy, frame_done;
    logic [IW-1:0] blk_index;
    logic          resp_done = 1'b0;
    logic          inj_done  = 1'b0;
    assign bus.tx_done = resp_done | inj_done;

    aes_block_uart_streamer #(.FIFO_DEPTH(FD), .BLOCK_COUNT(BC)) dut (
        .clk        (clk),
        .reset_n    (rst_n),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .blk_index  (blk_index)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard entry: {frame_end, next_byte_follows_in_1_cycle, byte}
    logic [9:0] exp_q[$];
    int         mdl_blk = 0;
    logic [7:0] mdl_csum = 8'h00;
    int         start_cnt = 0, first_start_cyc = -1;
    int         fd_seen = 0, fd_exp = 0;
    bit         abort = 1'b0, resp_busy = 1'b0;
    int         push_edge = 0, last_wait = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [127:0] d);
        logic [7:0] b;
        logic [9:0] last;
        for (int i = 0; i < 16; i++) begin
            b = d[8*i +: 8];
            mdl_csum ^= b;
            exp_q.push_back({1'b0, (i != 15), b});
        end
        mdl_blk++;
        if (mdl_blk == BC) begin
            mdl_blk = 0;
            fd_exp++;
            if (CS != 0) begin
                exp_q.push_back({2'b10, mdl_csum});
            end else begin
                last = exp_q.pop_back();
                last[9] = 1'b1;
                exp_q.push_back(last);
            end
            mdl_csum = 8'h00;
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        mdl_blk = 0;
        mdl_csum = 8'h00;
        start_cnt = 0;
        first_start_cyc = -1;
        fd_seen = 0;
        fd_exp = 0;
    endtask

    always @(negedge clk) if (frame_done) fd_seen <= fd_seen + 1;

    // UART transmitter model: tx_done comes 10 cycles after each tx_start.
    logic [7:0] resp_got;
    logic [9:0] resp_e;
    bit         resp_bad;
    initial begin
        forever begin
            @(negedge clk);
            while (bus.tx_start === 1'b1) begin
                resp_busy = 1'b1;
                start_cnt++;
                if (first_start_cyc < 0) first_start_cyc = cyc;
                resp_got = bus.tx_data;
                resp_e   = 10'd0;
                chk("sb_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    resp_e = exp_q.pop_front();
                    chk("tx_data", resp_got, resp_e[7:0]);
                end
                resp_bad = 1'b0;
                for (int k = 0; k < 9; k++) begin
                    @(negedge clk);
                    if (!abort && (bus.tx_start !== 1'b0 || bus.tx_data !== resp_got)) resp_bad = 1'b1;
                end
                chk("hold_no_restart", resp_bad, 1'b0);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
                if (!abort) begin
                    chk("frame_done_pulse", frame_done, resp_e[9]);
                    chk("next_start_gap", bus.tx_start, resp_e[8]);
                    if (resp_e[9]) chk("blk_index_wrap", blk_index, 0);
                end
            end
            resp_busy = 1'b0;
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        bus.blk_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_flush();
    endtask

    // Called at a negedge; holds valid until accepted, returns at the negedge after the transfer edge.
    task automatic push_blk(input logic [127:0] d);
        int n = 0;
        bus.blk_valid = 1'b1;
        bus.blk_data  = d;
        while (!bus.blk_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (n >= 2000) chk("push_timeout", n, 0);
        else begin
            model_push(d);
            push_edge = cyc + 1;
        end
        @(negedge clk);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || resp_busy || busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", n < limit, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    logic [127:0] blk0;
    int snap, n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        blk0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;

        // Single block, reset values, tx_done ignored in IDLE and in SEND
        reset_dut();
        #1;
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_blk_index", blk_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_blk_ready", bus.blk_ready, 1);
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_done_no_start", start_cnt, 0);
        chk("idle_done_not_busy", busy, 0);
        push_blk(blk0);
        bus.blk_valid = 1'b0;
        n = 0;
        while (!bus.tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        wait_drain(1000);
        chk("first_start_latency", first_start_cyc - push_edge, 2);
        chk("one_block_starts", start_cnt, (BC == 1) ? 16 + CS : 16);
        chk("one_block_index", blk_index, mdl_blk);
        chk("one_block_frames", fd_seen, fd_exp);

        // Back-to-back blocks until the FIFO fills, then one more that must wait
        reset_dut();
        @(negedge clk);
        for (int i = 0; i < 5; i++) push_blk({$urandom, $urandom, $urandom, $urandom});
        chk("ready_low_when_full", bus.blk_ready, 0);
        push_blk({$urandom, $urandom, $urandom, $urandom});
        bus.blk_valid = 1'b0;
        chk("full_push_stalled", last_wait > 100, 1'b1);
        wait_drain(5000);
        chk("multi_frames", fd_seen, fd_exp);
        chk("multi_blk_index", blk_index, mdl_blk);
        chk("multi_starts", start_cnt, 6 * 16 + CS * fd_exp);

        // Reset in the middle of a byte, stale tx_done, then restart
        reset_dut();
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_blk({$urandom, $urandom, $urandom, $urandom});
        bus.blk_valid = 1'b0;
        n = 0;
        while (start_cnt < 40 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_mid_byte", start_cnt >= 40, 1'b1);
        abort = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_start", bus.tx_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", bus.blk_ready, 1);
        chk("mid_rst_blk_index", blk_index, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (resp_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        model_flush();
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_done_no_start", start_cnt, 0);
        chk("stale_done_not_busy", busy, 0);
        push_blk(blk0);
        bus.blk_valid = 1'b0;
        wait_drain(1000);
        chk("restart_latency", first_start_cyc - push_edge, 2);
        chk("restart_blk_index", blk_index, mdl_blk);
        chk("restart_frames", fd_seen, fd_exp);

        // tx_done while idle after traffic
        snap = start_cnt;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_idle_no_start", start_cnt, snap);
        chk("late_idle_not_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
